// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// Module : pc_sequencer_pkg
// Brief  : Shared widths, reset defaults and state encoding for the PC sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

  localparam int                PC_W         = 6;
  localparam logic [PC_W-1:0]   RESET_PC_DEF = 6'd0;
  localparam logic [PC_W-1:0]   INC_DEF      = 6'd1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_RESOLVE = 3'd2,
    S_UPDATE  = 3'd3,
    S_BR_ADD  = 3'd4,
    S_HALTED  = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pc_next_adder.sv
// ============================================================================
// Module : pc_next_adder
// Brief  : Ripple-carry adder shared by the sequential increment and branch add.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_next_adder #(
  parameter int W = 6
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[W];

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module : pc_sequencer
// Brief  : Multi-cycle PC controller: fetch handshake, branch/jump resolution.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [PC_W-1:0] INC      = INC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            halt_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  output logic            instr_valid_o,
  input  logic            br_valid_i,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_offset_i,
  input  logic            jmp_i,
  input  logic [PC_W-1:0] jmp_target_i,
  output logic [PC_W-1:0] pc_o,
  output logic            wrap_o,
  output logic            busy_o
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] temp_q, temp_d;
  logic [PC_W-1:0] off_q, off_d;
  logic            wrap_q, wrap_d;
  logic            req_q, req_d;
  logic            halt_q;
  logic            iv_q;

  logic            halt_now;
  logic            fetch_req;
  logic            ack_ok;
  logic [PC_W-1:0] add_a, add_b, add_sum;
  logic            add_cout;

  // A halt arriving this cycle counts at the current boundary, not one later.
  assign halt_now  = halt_q | halt_i;
  // Request is withheld while stalled, but once raised it holds until ack.
  assign fetch_req = (state_q == S_FETCH) && (req_q || !stall_i);
  assign ack_ok    = fetch_req && imem_ack_i;

  assign add_a = (state_q == S_BR_ADD) ? temp_q : pc_q;
  assign add_b = (state_q == S_BR_ADD) ? off_q  : INC;

  pc_next_adder #(.W(PC_W)) u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    temp_d  = temp_q;
    off_d   = off_q;
    wrap_d  = wrap_q;
    req_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (halt_now)     state_d = S_HALTED;
        else if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (ack_ok) state_d = halt_now ? S_HALTED : S_RESOLVE;
        else        req_d   = fetch_req;
      end
      S_RESOLVE: begin
        if (halt_now) begin
          state_d = S_HALTED;
        end else if (br_valid_i && !stall_i) begin
          if (jmp_i) begin
            pc_d    = jmp_target_i;
            state_d = S_FETCH;
          end else if (br_taken_i) begin
            temp_d  = add_sum;
            off_d   = br_offset_i;
            state_d = S_BR_ADD;
          end else begin
            state_d = S_UPDATE;
          end
        end
      end
      S_UPDATE: begin
        if (!stall_i) begin
          pc_d    = add_sum;
          wrap_d  = wrap_q | add_cout;
          state_d = halt_now ? S_HALTED : S_FETCH;
        end
      end
      S_BR_ADD: begin
        if (!stall_i) begin
          pc_d    = add_sum;
          state_d = halt_now ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      temp_q  <= '0;
      off_q   <= '0;
      wrap_q  <= 1'b0;
      req_q   <= 1'b0;
      halt_q  <= 1'b0;
      iv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      temp_q  <= temp_d;
      off_q   <= off_d;
      wrap_q  <= wrap_d;
      req_q   <= req_d;
      halt_q  <= halt_q | halt_i;
      iv_q    <= ack_ok;
    end
  end

  assign imem_req_o    = fetch_req;
  assign imem_addr_o   = fetch_req ? pc_q : '0;
  assign instr_valid_o = iv_q;
  assign pc_o          = pc_q;
  assign wrap_o        = wrap_q;
  assign busy_o        = (state_q != S_IDLE) && (state_q != S_HALTED);

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle program-counter controller for the 6-bit MIPS fetch path. It owns the PC register and runs the fetch handshake with instruction memory. After each fetch it waits for branch/jump resolution and computes the next PC. One shared 6-bit ripple adder is time-multiplexed for both PC+1 and the branch-offset add.

Parameters:
RESET_PC, 6'd0, PC value loaded on reset and held in IDLE
INC, 6'd1, sequential increment operand fed to adder

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE and begin fetching (sampled in IDLE only)
halt  in  1  request stop; sticky internally until HALTED reached
stall  in  1  freeze sequencing (see rules)
imem_req  out  1  fetch request to instruction memory
imem_addr  out  6  fetch address (= pc while imem_req=1, else 0)
imem_ack  in  1  memory accepted/returned instruction (1-cycle pulse)
instr_valid  out  1  1-cycle pulse, cycle after imem_ack accepted
br_valid  in  1  resolution for current instruction is present this cycle
br_taken  in  1  conditional branch taken (qualified by br_valid)
br_offset  in  6  two's-complement word offset, relative to pc+1
jmp  in  1  absolute jump (qualified by br_valid); priority over br_taken
jmp_target  in  6  absolute jump target
pc  out  6  current PC register
wrap  out  1  sticky: sequential increment carried out of bit 5
busy  out  1  1 in any state except IDLE and HALTED

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, wrap=0, imem_req=0, instr_valid=0, internal temp=0, halt latch=0. Outputs clear immediately, not at the next edge. Reset mid-handshake abandons the fetch; the memory side must tolerate a dropped req.
- States: IDLE, FETCH, RESOLVE, UPDATE, BR_ADD, HALTED.
- IDLE: start=1 -> FETCH. Halt latch set while in IDLE -> HALTED.
- FETCH: imem_req=1 and imem_addr=pc. Once raised, req stays high until the imem_ack cycle. req drops the cycle after ack.
  - If stall=1 on FETCH entry, req is withheld until stall=0.
  - On ack: instr_valid=1 next cycle, and the state goes to RESOLVE (or HALTED if the halt latch is set).
- RESOLVE: waits for br_valid=1 with stall=0. br_valid while stall=1 is ignored; the source must re-present it.
  - jmp=1: pc<=jmp_target -> FETCH (adder unused).
  - else br_taken=1: temp<=pc+INC -> BR_ADD.
  - else -> UPDATE.
  - Halt latch set -> HALTED, pc unchanged.
- UPDATE: pc<=pc+INC via adder; carry-out=1 sets wrap. Then -> FETCH, or HALTED if halted. stall=1 holds the state with pc unchanged.
- BR_ADD: pc<=temp+br_offset_latched, mod 64; carry ignored, wrap not touched. Then -> FETCH. br_offset and br_taken are latched in RESOLVE. stall holds the state.
- HALTED: absorbing; exit only by reset. imem_req=0, busy=0.
- Halt is latched on any cycle and acted on at the next state boundary. An in-flight fetch handshake always completes first.
- Adder muxing: operand A = pc (UPDATE, RESOLVE) or temp (BR_ADD). Operand B = INC or br_offset. Adder carry-in is tied 0.
- Latency with zero memory wait and br_valid in the first RESOLVE cycle:
  - sequential: 3 cycles per instruction
  - jump: 2 cycles
  - taken branch: 3 cycles
- Simultaneous events:
  - jmp and br_taken both 1: jmp wins.
  - halt and start together in IDLE: HALTED.
  - stall and imem_ack in the same cycle: ack is honoured.

Decomposition:
- Shared package: state encoding constants (3-bit), PC_W=6, RESET_PC default.
- Sub-module pc_next_adder: 6-bit adder with cin, sum and cout, instantiated once and shared. All sequencing stays in pc_sequencer.

Test Plan:
- Reset then start, 1-cycle ack each fetch, br_valid with no branch ×3 -> imem_addr 0,1,2; instr_valid pulses; pc=3; wrap=0.
- pc=10, br_taken=1, br_offset=6'h3E (-2) -> BR_ADD gives pc=9; next imem_addr=9; wrap unchanged.
- pc=63 sequential -> pc=0 and wrap=1 sticky. Then jmp to 5 with br_taken=1 -> pc=5 (jmp priority), wrap stays 1.
- imem_ack delayed 4 cycles with stall toggling mid-wait -> req stays high, addr stable, exactly one instr_valid.
- halt asserted during FETCH wait -> after ack, state=HALTED, busy=0, req=0; further start ignored.
- rst_n pulled low mid-BR_ADD, asynchronously between edges -> outputs cleared before the next edge; pc=RESET_PC after release.
